// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: streams a program into imem, runs the core for run_len cycles, then dumps state words.
module prog_load_ctrl #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 16,
  parameter int DUMP_W  = 64,
  parameter int DUMP_N  = 32,
  localparam int LEN_W  = $clog2(DEPTH) + 1,
  localparam int IDX_W  = $clog2(DUMP_N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst_n,
  output logic               cpu_en,
  output logic [IDX_W-1:0]   dump_idx,
  input  logic [DUMP_W-1:0]  dump_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DUMP_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy,
  output logic               done
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, DUMP = 3'd3, DONE = 3'd4;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_N - 1);
  logic [2:0]       state;
  logic [LEN_W-1:0] eff_len, word_idx, len_c;
  logic [CNT_W-1:0] run_cnt, cyc_cnt;
  logic             load_last;
  always_comb begin
    len_c      = len > DEPTH_L ? DEPTH_L : len;
    load_last  = word_idx == eff_len - LEN_W'(1);
    s_ready    = state == LOAD && !abort;
    imem_we    = s_valid && s_ready;
    imem_addr  = ADDR_W'({word_idx, 2'b00});
    imem_wdata = imem_we ? s_data : '0;
    cpu_rst_n  = state == RUN || state == DUMP || state == DONE;
    cpu_en     = state == RUN;
    m_valid    = state == DUMP && !abort;
    m_data     = dump_rdata;
    m_last     = state == DUMP && dump_idx == LAST_IDX;
    busy       = state != IDLE;
    done       = state == DONE && !abort;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      eff_len  <= '0;
      run_cnt  <= '0;
      word_idx <= '0;
      cyc_cnt  <= '0;
      dump_idx <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          eff_len  <= len_c;
          run_cnt  <= run_len;
          word_idx <= '0;
          cyc_cnt  <= '0;
          dump_idx <= '0;
          state    <= len_c != '0 ? LOAD : run_len != '0 ? RUN : DUMP;
        end
        LOAD: if (imem_we) begin
          word_idx <= load_last ? word_idx : word_idx + LEN_W'(1);
          if (load_last) state <= run_cnt != '0 ? RUN : DUMP;
        end
        RUN: begin
          cyc_cnt <= cyc_cnt + CNT_W'(1);
          if (cyc_cnt == run_cnt - CNT_W'(1)) state <= DUMP;
        end
        DUMP: if (m_valid && m_ready) begin
          dump_idx <= dump_idx + IDX_W'(1);
          if (m_last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed table of load/run/dump sequences plus abort and async-reset corner cases.
module tb_prog_load_ctrl;
  localparam int LEN_W = 9, CNT_W = 16, IDX_W = 5;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, s_valid = 0, m_ready = 0;
  logic [LEN_W-1:0] len = 0;
  logic [CNT_W-1:0] run_len = 0;
  logic [31:0] s_data = 0;
  logic s_ready, imem_we, cpu_rst_n, cpu_en, m_valid, m_last, busy, done;
  logic [63:0] imem_addr, m_data, dump_rdata;
  logic [31:0] imem_wdata;
  logic [IDX_W-1:0] dump_idx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign dump_rdata = {32'hA5A5_0000, 27'd0, dump_idx};
  prog_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len), .run_len(run_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
    .dump_idx(dump_idx), .dump_rdata(dump_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );
  typedef struct {
    int l; int r; bit gap; bit stall; int w; int la; int rc; int tot;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_s_ready"}, s_ready, 0);
    chk({n, "_imem_we"}, imem_we, 0);
    chk({n, "_imem_addr"}, imem_addr, 0);
    chk({n, "_imem_wdata"}, imem_wdata, 0);
    chk({n, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({n, "_cpu_en"}, cpu_en, 0);
    chk({n, "_dump_idx"}, dump_idx, 0);
    chk({n, "_m_valid"}, m_valid, 0);
    chk({n, "_m_last"}, m_last, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
  endtask
  task automatic run_seq(input int l, input int r, input bit gap, input bit stall,
                         output int w, output int la, output int rc, output int rd,
                         output int dn, output int tot, output int rw);
    int t, st, last_t;
    bit prev_rst, to, seen_mv;
    w = 0; la = 0; rc = 0; rd = 0; dn = 0; rw = -1; t = 0; st = 3; last_t = 0;
    prev_rst = 0; to = 1; seen_mv = 0;
    @(negedge clk);
    start = 1; len = LEN_W'(l); run_len = CNT_W'(r); abort = 0; s_valid = 0; m_ready = 1;
    @(posedge clk);
    tot = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 3000; k++) begin
      s_valid = gap ? (t % 2 == 0) : 1'b1;
      s_data = 32'hC0DE_0000 | w;
      m_ready = !(stall && rd == 10 && st > 0);
      #1;
      if (!busy) begin
        to = 0;
        break;
      end
      if (imem_we) begin
        chk("imem_addr", imem_addr, 64'(4 * w));
        chk("imem_wdata", imem_wdata, 32'hC0DE_0000 | w);
        la = 4 * w; w++; last_t = t;
      end
      if (cpu_rst_n && !prev_rst) begin
        rw = w;
        if (w > 0) chk("rst_rise_lat", t - last_t, 1);
      end
      prev_rst = cpu_rst_n;
      if (cpu_en) rc++;
      if (m_valid && !seen_mv) begin
        seen_mv = 1;
        chk("run_before_dump", rc, r);
      end
      if (m_valid && m_ready) begin
        chk("m_data", m_data, {32'hA5A5_0000, 32'(rd)});
        chk("m_last", m_last, rd == 31);
        rd++;
      end
      if (m_valid && !m_ready) st--;
      if (done) dn++;
      @(posedge clk);
      tot++; t++;
      @(negedge clk);
    end
    chk("timeout", to, 0);
    s_valid = 0;
  endtask
  initial begin
    int w, la, rc, rd, dn, tot, rw, ec;
    tv[0] = '{15, 20, 0, 0, 15, 56, 20, 69};
    tv[1] = '{15, 20, 1, 1, 15, 56, 20, 86};
    tv[2] = '{0, 0, 0, 0, 0, 0, 0, 34};
    tv[3] = '{266, 3, 0, 0, 256, 1020, 3, 293};
    tv[4] = '{1, 1, 0, 0, 1, 0, 1, 36};
    tv[5] = '{0, 5, 1, 0, 0, 0, 5, 39};
    @(negedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      run_seq(tv[i].l, tv[i].r, tv[i].gap, tv[i].stall, w, la, rc, rd, dn, tot, rw);
      chk($sformatf("v%0d_writes", i), w, tv[i].w);
      chk($sformatf("v%0d_last_addr", i), la, tv[i].la);
      chk($sformatf("v%0d_run_cycles", i), rc, tv[i].rc);
      chk($sformatf("v%0d_dump_words", i), rd, 32);
      chk($sformatf("v%0d_done_pulses", i), dn, 1);
      chk($sformatf("v%0d_total_cycles", i), tot, tv[i].tot);
      chk($sformatf("v%0d_rst_rise_words", i), rw, tv[i].w);
    end
    @(negedge clk);
    start = 1; abort = 1; len = 5; run_len = 5;
    @(negedge clk);
    start = 0; abort = 0;
    #1;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_s_ready", s_ready, 0);
    @(negedge clk);
    start = 1; len = 4; run_len = 10;
    @(negedge clk);
    start = 0; s_valid = 1;
    ec = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (cpu_en) ec++;
      if (ec == 5) break;
      @(negedge clk);
    end
    chk("abort_run_reached", ec, 5);
    abort = 1;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    abort = 0; s_valid = 0;
    #1;
    chk("abort_cpu_en", cpu_en, 0);
    chk("abort_cpu_rst_n", cpu_rst_n, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done_after", done, 0);
    run_seq(4, 10, 0, 0, w, la, rc, rd, dn, tot, rw);
    chk("post_abort_writes", w, 4);
    chk("post_abort_run", rc, 10);
    chk("post_abort_done", dn, 1);
    chk("post_abort_total", tot, 48);
    @(negedge clk);
    start = 1; len = 10; run_len = 5;
    @(negedge clk);
    start = 0; s_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("midload_we", imem_we, 1);
    chk("midload_addr", imem_addr, 12);
    #2;
    rst_n = 0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1; s_valid = 0;
    #1;
    chk("post_rst_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
# prog_load_ctrl

Parametrised program-load and state-dump controller for the pipeline CPU test environment. It streams instruction words into instruction memory at consecutive word addresses while holding the core in reset. It then releases the core for a programmed number of cycles, freezes it, and streams out a configurable window of architectural state (register file or data memory words) over a valid/ready port. It sits between the bench or host stream source and the CPU top, replacing ad-hoc load and dump loops with one reusable, handshaked block.

## Interface
Parameters:
- INSTR_W, 32, instruction word width
- ADDR_W, 64, byte-address width driven to instruction memory
- DEPTH, 256, instruction memory depth in words; LEN_W = clog2(DEPTH)+1
- CNT_W, 16, width of run-cycle counter
- DUMP_W, 64, width of dumped state words
- DUMP_N, 32, number of state words dumped; IDX_W = clog2(DUMP_N)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load/run/dump sequence
- abort  in  1  synchronous return to IDLE from any state
- len  in  LEN_W  words to load, sampled on accepted start
- run_len  in  CNT_W  CPU run cycles, sampled on accepted start
- s_valid  in  1  instruction stream valid
- s_ready  out  1  instruction stream ready
- s_data  in  INSTR_W  instruction word
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  byte address = 4 × word index
- imem_wdata  out  INSTR_W  write data
- cpu_rst_n  out  1  core reset, active low
- cpu_en  out  1  core clock-enable / run permission
- dump_idx  out  IDX_W  index into the state source
- dump_rdata  in  DUMP_W  state word at dump_idx, combinational
- m_valid / m_ready  out / in  1  dump stream handshake
- m_data  out  DUMP_W  dump word
- m_last  out  1  marks final dump word
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at sequence completion

## Operation
- FSM states are IDLE, LOAD, RUN, DUMP, DONE.
- IDLE: start=1 latches eff_len = min(len, DEPTH) and run_len. It clears word_idx, cyc_cnt, and dump_idx.
  - Next state is LOAD if eff_len>0.
  - Otherwise next state is RUN if run_len>0, else DUMP.
  - start is ignored outside IDLE.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready: imem_we=1, imem_addr = {word_idx,2'b00} zero-extended, imem_wdata=s_data, then word_idx++.
  - Leave LOAD on the transfer with word_idx==eff_len-1. Next state is RUN, or DUMP if run_len==0.
  - Gaps in s_valid only stall the load.
- RUN: cpu_en=1. cyc_cnt increments each cycle. When cyc_cnt==run_len-1, go to DUMP, so the core runs exactly run_len cycles.
- DUMP:
  - cpu_en=0, so the core is frozen and its state is stable.
  - m_valid=1, m_data=dump_rdata, m_last=(dump_idx==DUMP_N-1).
  - On m_valid&m_ready: dump_idx++. After the last word, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cpu_rst_n:
  - 0 in IDLE and LOAD.
  - 1 in RUN, DUMP, DONE.
  - Core state is therefore preserved through dump and cleared at the next load.
- abort=1 wins over every other event. It forces IDLE next cycle, drops all strobes that cycle, and no done pulse is produced.
- s_ready, imem_we, m_valid, and cpu_en are all 0 outside their own states.

## Timing
- Reset values: state IDLE, s_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst_n 0, cpu_en 0, dump_idx 0, m_valid 0, m_data = dump_rdata (don't-care), m_last 0, busy 0, done 0.
- Outputs are decoded from registered state and counters. imem_we, imem_addr, and imem_wdata are combinational from the handshake, so the memory writes on the same edge the word is accepted.
- Latencies:
  - start to first possible accept: 1 cycle.
  - Last accepted word to cpu_rst_n=1: next cycle.
- Full sequence with no stalls: 1 + eff_len + run_len + DUMP_N + 1 cycles to return to IDLE.
- Wrap-around: word_idx never exceeds DEPTH-1, because len>DEPTH is clamped.
- Reset asserted mid-sequence: immediate return to the reset values above, with no partial done.
- start in the same cycle as abort in IDLE: abort wins and the sequence does not start.

## Test plan
- Load len=15 with continuous s_valid, run_len=20, DUMP_N=32.
  - imem writes go to addresses 0,4,…,56.
  - cpu_rst_n rises the cycle after the 15th word; cpu_en is high for exactly 20 cycles.
  - 32 words stream out with m_last on index 31, then a done pulse; 69 cycles total.
- s_valid toggled every other cycle and m_ready held low for 3 cycles mid-dump: no word is lost or duplicated, and the imem_addr and dump_idx sequences stay strictly consecutive.
- len=0, run_len=0: IDLE→DUMP directly, no imem_we, cpu_en never high.
- len=DEPTH+10: exactly DEPTH writes, last address 4·(DEPTH-1), then RUN.
- abort during RUN at cycle 5, then a new start: cpu_en drops next cycle, cpu_rst_n returns to 0, no done pulse, and the new sequence proceeds normally.
- rst_n pulsed low asynchronously mid-LOAD: all outputs take their reset values without waiting for a clock edge, and busy=0.
